pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipe_hazard_ctrl_perf_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants: FSM encoding, hazard classes and
// the per-hazard stall/bubble patterns.
package pipe_hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_BUSY = 1'b1;

  // Hazard classes, listed highest priority first
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_MEM_WAIT = 3'd1,
    HZ_MDU      = 3'd2,
    HZ_LOAD_USE = 3'd3,
    HZ_BRANCH   = 3'd4
  } hazard_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_bubble;
    logic idex_bubble;
    logic exmem_bubble;
    logic memwb_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTL_NONE     = 8'b0000_0000;
  localparam hz_ctrl_t CTL_MEM_WAIT = 8'b1111_0001;
  localparam hz_ctrl_t CTL_MDU      = 8'b1110_0010;
  localparam hz_ctrl_t CTL_LOAD_USE = 8'b1100_0100;
  localparam hz_ctrl_t CTL_BRANCH   = 8'b0000_1000;

  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic       use_rs,
    input logic [4:0] rs,
    input logic       use_rt,
    input logic [4:0] rt
  );
    return mem_read && (ex_rt != 5'd0) &&
           ((use_rs && (rs == ex_rt)) ||
            (use_rt && (rt == ex_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Wrapping event counter with synchronous clear that beats
// a same-cycle increment.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/bubble
// generation, multi-cycle MDU stall FSM and perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_addr,
  input  logic             id_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [0:0] state;
  logic [0:0] state_nx;
  logic [7:0] mdu_cnt;
  logic [7:0] mdu_cnt_nx;

  logic     mem_wait;
  logic     mdu_act;
  logic     lu_act;
  logic     last_cyc;
  hazard_e  hz;
  hz_ctrl_t ctl;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign mdu_act  = (state == ST_MDU_BUSY) | ex_mdu_start;
  assign last_cyc = (state == ST_MDU_BUSY) &&
                    (mdu_cnt == 8'd1);
  assign lu_act   = load_use_hit(ex_mem_read, ex_rt_addr,
                                 id_use_rs, id_rs_addr,
                                 id_use_rt, id_rt_addr);

  // Terms are made one-hot so lower hazards are masked
  always_comb begin
    hz = HZ_NONE;
    unique case (1'b1)
      mem_wait:
        hz = HZ_MEM_WAIT;
      mdu_act & ~mem_wait:
        hz = HZ_MDU;
      lu_act & ~mem_wait & ~mdu_act:
        hz = HZ_LOAD_USE;
      id_branch_taken & ~mem_wait & ~mdu_act & ~lu_act:
        hz = HZ_BRANCH;
      default:
        hz = HZ_NONE;
    endcase
  end

  always_comb begin
    ctl = CTL_NONE;
    unique case (hz)
      HZ_MEM_WAIT: ctl = CTL_MEM_WAIT;
      HZ_MDU:      ctl = CTL_MDU;
      HZ_LOAD_USE: ctl = CTL_LOAD_USE;
      HZ_BRANCH:   ctl = CTL_BRANCH;
      default:     ctl = CTL_NONE;
    endcase
  end

  assign pc_stall     = ctl.pc_stall;
  assign ifid_stall   = ctl.ifid_stall;
  assign idex_stall   = ctl.idex_stall;
  assign exmem_stall  = ctl.exmem_stall;
  assign ifid_bubble  = ctl.ifid_bubble;
  assign idex_bubble  = ctl.idex_bubble;
  assign exmem_bubble = ctl.exmem_bubble;
  assign memwb_bubble = ctl.memwb_bubble;
  assign mdu_done     = (hz == HZ_MDU) & last_cyc;

  // Final MDU cycle is held while memory stalls the pipe
  always_comb begin
    state_nx   = state;
    mdu_cnt_nx = mdu_cnt;
    unique case (state)
      ST_RUN: begin
        if (ex_mdu_start) begin
          state_nx   = ST_MDU_BUSY;
          mdu_cnt_nx = 8'(MDU_LAT - 1);
        end
      end
      ST_MDU_BUSY: begin
        if (mdu_cnt == 8'd1) begin
          if (!mem_wait) begin
            state_nx   = ST_RUN;
            mdu_cnt_nx = 8'd0;
          end
        end else begin
          mdu_cnt_nx = mdu_cnt - 8'd1;
        end
      end
      default: begin
        state_nx   = ST_RUN;
        mdu_cnt_nx = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_RUN;
      mdu_cnt <= 8'd0;
    end else begin
      state   <= state_nx;
      mdu_cnt <= mdu_cnt_nx;
    end
  end

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (perf_clr),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (perf_clr),
    .inc   (ifid_bubble),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic
// against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rt_addr;
  logic id_use_rs, id_use_rt, ex_mem_read;
  logic id_branch_taken, ex_mdu_start;
  logic dmem_req, dmem_ready, perf_clr;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_bubble, idex_bubble, exmem_bubble;
  logic memwb_bubble, mdu_done;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr),
    .id_branch_taken(id_branch_taken),
    .ex_mdu_start(ex_mdu_start),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_bubble(ifid_bubble), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble),
    .memwb_bubble(memwb_bubble), .mdu_done(mdu_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Reference model: m_left = MDU stall cycles still owed
  int m_left;
  int cur;
  logic mw, lu;
  logic [8:0] exp_v;
  logic [CW-1:0] m_stall, m_flush;

  always_comb begin
    mw  = dmem_req && !dmem_ready;
    cur = (m_left > 0) ? m_left : (ex_mdu_start ? LAT : 0);
    lu  = ex_mem_read && ex_rt_addr != 0 &&
          ((id_use_rs && id_rs_addr == ex_rt_addr) ||
           (id_use_rt && id_rt_addr == ex_rt_addr));
    exp_v = 9'b0;
    if (mw)                   exp_v = 9'b1111_0001_0;
    else if (cur > 0)         exp_v = {8'b1110_0010, cur == 1};
    else if (lu)              exp_v = 9'b1100_0100_0;
    else if (id_branch_taken) exp_v = 9'b0000_1000_0;
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_left  <= 0;
      m_stall <= '0;
      m_flush <= '0;
    end else begin
      if (cur == 0)      m_left <= 0;
      else if (cur == 1) m_left <= mw ? 1 : 0;
      else               m_left <= cur - 1;
      m_stall <= perf_clr ? '0 : m_stall + CW'(exp_v[8]);
      m_flush <= perf_clr ? '0 : m_flush + CW'(exp_v[4]);
    end
  end

  function automatic logic [8:0] dut_v();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall,
            ifid_bubble, idex_bubble, exmem_bubble,
            memwb_bubble, mdu_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs_addr = 0; id_rt_addr = 0; ex_rt_addr = 0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0;
    id_branch_taken = 0; ex_mdu_start = 0;
    dmem_req = 0; dmem_ready = 1; perf_clr = 0;
  endtask

  task automatic clr_counters();
    idle();
    perf_clr = 1;
    tick();
    perf_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++;
    if (dut_v() !== 9'b0 || stall_cycles !== 0 ||
        flush_count !== 0) begin
      errors++;
      $display("FAIL reset_idle got %b/%0d/%0d want 0/0/0",
               dut_v(), stall_cycles, flush_count);
    end
    id_branch_taken = 1;
    #1;
    checks++;
    if (dut_v() !== 9'b0000_1000_0) begin
      errors++;
      $display("FAIL reset_comb got %b want %b",
               dut_v(), 9'b0000_1000_0);
    end
    idle();
    @(negedge clk);
    nrst = 1;
    tick();
  endtask

  task automatic test_load_use();
    clr_counters();
    ex_mem_read = 1; ex_rt_addr = 5;
    id_rs_addr = 5; id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (dut_v() !== 9'b1100_0100_0 || stall_cycles !== 0) begin
      errors++;
      $display("FAIL load_use got %b/%0d want %b/0",
               dut_v(), stall_cycles, 9'b1100_0100_0);
    end
    tick();
    checks++;
    if (stall_cycles !== 1) begin
      errors++;
      $display("FAIL lu_count got %0d want 1", stall_cycles);
    end
    ex_rt_addr = 0; id_rs_addr = 0;
    @(negedge clk);
    checks++;
    if (dut_v() !== 9'b0) begin
      errors++;
      $display("FAIL lu_r0 got %b want 0", dut_v());
    end
    tick();
    idle();
  endtask

  task automatic test_mdu();
    clr_counters();
    for (int i = 0; i < 6; i++) begin
      ex_mdu_start = (i == 0);
      @(negedge clk);
      checks++;
      if ({pc_stall, exmem_bubble, mdu_done} !==
          {i < 4, i < 4, i == 3}) begin
        errors++;
        $display("FAIL mdu_c%0d got %b%b%b want %b%b%b", i,
                 pc_stall, exmem_bubble, mdu_done,
                 i < 4, i < 4, i == 3);
      end
      tick();
    end
    idle();
    checks++;
    if (stall_cycles !== 4) begin
      errors++;
      $display("FAIL mdu_count got %0d want 4", stall_cycles);
    end
  endtask

  task automatic test_mdu_mem_wait();
    logic w;
    clr_counters();
    for (int i = 0; i < 9; i++) begin
      w = (i >= 3 && i <= 5);
      ex_mdu_start = (i == 0);
      dmem_req = w;
      dmem_ready = !w;
      @(negedge clk);
      checks++;
      if ({pc_stall, exmem_bubble, memwb_bubble, mdu_done} !==
          {i <= 6, i <= 6 && !w, w, i == 6}) begin
        errors++;
        $display("FAIL mdu_mw_c%0d got %b%b%b%b want %b%b%b%b",
                 i, pc_stall, exmem_bubble, memwb_bubble,
                 mdu_done, i <= 6, i <= 6 && !w, w, i == 6);
      end
      tick();
    end
    idle();
    checks++;
    if (stall_cycles !== 7) begin
      errors++;
      $display("FAIL mdu_mw_count got %0d want 7",
               stall_cycles);
    end
  endtask

  task automatic test_branch_masked();
    clr_counters();
    ex_mem_read = 1; ex_rt_addr = 7;
    id_rt_addr = 7; id_use_rt = 1;
    id_branch_taken = 1;
    @(negedge clk);
    checks++;
    if ({pc_stall, ifid_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL br_masked got %b%b want 10",
               pc_stall, ifid_bubble);
    end
    tick();
    ex_mem_read = 0;
    @(negedge clk);
    checks++;
    if (dut_v() !== 9'b0000_1000_0) begin
      errors++;
      $display("FAIL br_retry got %b want %b",
               dut_v(), 9'b0000_1000_0);
    end
    tick();
    idle();
    checks++;
    if (flush_count !== 1 || stall_cycles !== 1) begin
      errors++;
      $display("FAIL br_count got %0d/%0d want 1/1",
               flush_count, stall_cycles);
    end
  endtask

  task automatic test_reset_mid_mdu();
    clr_counters();
    ex_mdu_start = 1;
    tick();
    ex_mdu_start = 0;
    tick();
    nrst = 0;
    #1;
    checks++;
    if (dut_v() !== 9'b0 || stall_cycles !== 0 ||
        flush_count !== 0) begin
      errors++;
      $display("FAIL rst_mdu got %b/%0d/%0d want 0/0/0",
               dut_v(), stall_cycles, flush_count);
    end
    @(negedge clk);
    nrst = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({pc_stall, mdu_done} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mdu_c%0d got %b%b want 00",
                 i, pc_stall, mdu_done);
      end
      tick();
    end
  endtask

  task automatic test_perf_clr();
    clr_counters();
    ex_mem_read = 1; ex_rt_addr = 3;
    id_rs_addr = 3; id_use_rs = 1;
    tick();
    perf_clr = 1;
    @(negedge clk);
    checks++;
    if (pc_stall !== 1'b1 || stall_cycles !== 1) begin
      errors++;
      $display("FAIL clr_pre got %b/%0d want 1/1",
               pc_stall, stall_cycles);
    end
    tick();
    perf_clr = 0;
    checks++;
    if (stall_cycles !== 0) begin
      errors++;
      $display("FAIL clr_wins got %0d want 0", stall_cycles);
    end
    tick();
    idle();
    checks++;
    if (stall_cycles !== 1) begin
      errors++;
      $display("FAIL clr_after got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      id_rs_addr = 5'($urandom_range(0, 3));
      id_rt_addr = 5'($urandom_range(0, 3));
      ex_rt_addr = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      ex_mem_read = 1'($urandom);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      ex_mdu_start = ($urandom_range(0, 9) == 0);
      dmem_req = 1'($urandom);
      dmem_ready = ($urandom_range(0, 3) != 0);
      perf_clr = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      checks++;
      if (dut_v() !== exp_v) begin
        errors++;
        $display("FAIL rnd_ctl_%0d got %b want %b",
                 i, dut_v(), exp_v);
      end
      checks++;
      if (stall_cycles !== m_stall ||
          flush_count !== m_flush) begin
        errors++;
        $display("FAIL rnd_cnt_%0d got %0d/%0d want %0d/%0d", i,
                 stall_cycles, flush_count, m_stall, m_flush);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_mdu_mem_wait();
    test_branch_masked();
    test_reset_mid_mdu();
    test_perf_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
